cap_sensor_scanner: RTL and testbench

// Input-side counterpart to the LED output path: the processor drives LEDs, this block reads the 9 pads.

---
 rtl/cap_sensor_scanner.sv | 148 ++++++++++++++
 tb/tb_cap_sensor_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module      : cap_sensor_scanner
// Description : Charge-time scanner for the capacitive touch pads, with
//               per-pad debounce, a live touched mask and sticky hit flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cap_sensor_scanner #(
    parameter int N_PADS           = 9,
    parameter int CNT_W            = 16,
    parameter int DISCHARGE_CYCLES = 1000,
    parameter int TIMEOUT          = 4000,
    parameter int THRESHOLD        = 1500,
    parameter int DEBOUNCE_SCANS   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PADS-1:0] capacitive_sensors_in,
    output logic              capacitive_sensors_out,
    output logic [N_PADS-1:0] touched,
    output logic [N_PADS-1:0] hits,
    input  logic [N_PADS-1:0] hit_clear,
    output logic              scan_done
);

    localparam logic [1:0] c_st_discharge = 2'd0;
    localparam logic [1:0] c_st_charge    = 2'd1;
    localparam logic [1:0] c_st_evaluate  = 2'd2;

    localparam int DB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    localparam logic [CNT_W-1:0] c_discharge_last = CNT_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_timeout        = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_threshold      = CNT_W'(THRESHOLD);
    localparam logic [DB_W-1:0]  c_db_last        = DB_W'(DEBOUNCE_SCANS - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_PADS-1:0] r_sync_meta;
    logic [N_PADS-1:0] r_sync_in;
    logic [N_PADS-1:0] r_latched;
    logic [CNT_W-1:0]  r_rise   [N_PADS];
    logic [DB_W-1:0]   r_db_cnt [N_PADS];
    logic [N_PADS-1:0] r_touched;
    logic [N_PADS-1:0] r_hits;

    logic [N_PADS-1:0] w_latched_next;
    logic              w_charge_done;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [N_PADS-1:0] w_raw;
    logic [N_PADS-1:0] w_touched_next;
    logic [DB_W-1:0]   w_db_next [N_PADS];
    logic [N_PADS-1:0] w_touch_rise;

    assign w_latched_next = r_latched | r_sync_in;
    // Early exit counts pads latching on this very cycle.
    assign w_charge_done  = (&w_latched_next) || (r_cnt == c_timeout_last);
    assign w_cnt_inc      = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    generate
        for (genvar gi = 0; gi < N_PADS; gi++) begin : g_raw
            assign w_raw[gi] = (r_rise[gi] >= c_threshold);
        end
    endgenerate

    always_comb begin
        w_touched_next = r_touched;
        for (int i = 0; i < N_PADS; i++) begin
            w_db_next[i] = r_db_cnt[i];
            if (w_raw[i] == r_touched[i]) begin
                w_db_next[i] = '0;
            end else if (r_db_cnt[i] == c_db_last) begin
                w_touched_next[i] = w_raw[i];
                w_db_next[i]      = '0;
            end else begin
                w_db_next[i] = r_db_cnt[i] + 1'b1;
            end
        end
    end

    assign w_touch_rise = (r_state == c_st_evaluate) ? (w_touched_next & ~r_touched) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_st_discharge;
            r_cnt       <= '0;
            r_sync_meta <= '0;
            r_sync_in   <= '0;
            r_latched   <= '0;
            r_touched   <= '0;
            r_hits      <= '0;
            for (int i = 0; i < N_PADS; i++) begin
                r_rise[i]   <= '0;
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync_meta <= capacitive_sensors_in;
            r_sync_in   <= r_sync_meta;
            // A new rising edge of touched outranks a same-cycle clear.
            r_hits      <= (r_hits & ~hit_clear) | w_touch_rise;
            case (r_state)
                c_st_discharge: begin
                    if (r_cnt == c_discharge_last) begin
                        r_state <= c_st_charge;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_st_charge: begin
                    r_latched <= w_latched_next;
                    for (int i = 0; i < N_PADS; i++) begin
                        if (r_sync_in[i] && !r_latched[i]) begin
                            r_rise[i] <= r_cnt;
                        end else if (w_charge_done && !w_latched_next[i]) begin
                            r_rise[i] <= c_timeout;
                        end
                    end
                    if (w_charge_done) begin
                        r_state <= c_st_evaluate;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_st_evaluate: begin
                    r_touched <= w_touched_next;
                    r_db_cnt  <= w_db_next;
                    r_latched <= '0;
                    r_state   <= c_st_discharge;
                    r_cnt     <= '0;
                end
                default: begin
                    r_state <= c_st_discharge;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign capacitive_sensors_out = (r_state == c_st_charge);
    assign scan_done              = (r_state == c_st_evaluate);
    assign touched                = r_touched;
    assign hits                   = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_cap_sensor_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_cap_sensor_scanner
// Description : Scan-level reference model bench for cap_sensor_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cap_sensor_scanner;

    localparam int N   = 9;
    localparam int DC  = 4;
    localparam int TO  = 64;
    localparam int THR = 20;
    localparam int DS  = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] pads = '0;
    logic [N-1:0] hit_clear = '0;
    logic         sensors_out;
    logic [N-1:0] touched;
    logic [N-1:0] hits;
    logic         scan_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = -1;

    // Per-scan plan: -2 pad already high at charge start, -1 never rises,
    // k >= 0 pad driven high during the cycle the charge counter equals k.
    int kk [N];
    int mode [N];

    // Reference model state
    logic [N-1:0] m_touched = '0;
    logic [N-1:0] m_hits = '0;
    int           m_cnt [N];

    cap_sensor_scanner #(
        .N_PADS(N), .CNT_W(16), .DISCHARGE_CYCLES(DC), .TIMEOUT(TO),
        .THRESHOLD(THR), .DEBOUNCE_SCANS(DS)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .capacitive_sensors_in (pads),
        .capacitive_sensors_out(sensors_out),
        .touched               (touched),
        .hits                  (hits),
        .hit_clear             (hit_clear),
        .scan_done             (scan_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_touched = '0;
        m_hits    = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        last_done = -1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) kk[i] = v;
    endtask

    // Entered on the first discharge cycle; ends on charge cycle 0.
    task automatic discharge_check();
        for (int j = 0; j < DC; j++) begin
            chk("discharge_out", sensors_out, 1'b0);
            tick();
        end
        chk("charge_start_out", sensors_out, 1'b1);
    endtask

    task automatic run_scan(input logic [N-1:0] clr);
        int rise [N];
        int maxr;
        int len;
        int n;
        bit all_risen;
        logic [N-1:0] old_t;
        all_risen = 1'b1;
        maxr = 0;
        for (int i = 0; i < N; i++) begin
            if (kk[i] == -2)                         rise[i] = 0;
            else if (kk[i] >= 0 && kk[i] + 2 < TO)   rise[i] = kk[i] + 2;
            else                                     rise[i] = TO;
            if (rise[i] == TO) all_risen = 1'b0;
            if (rise[i] > maxr) maxr = rise[i];
        end
        len = all_risen ? maxr + 1 : TO;

        n = 0;
        while (sensors_out === 1'b1 && n < 200) begin
            for (int i = 0; i < N; i++) if (kk[i] == n) pads[i] = 1'b1;
            tick();
            n++;
        end
        chk("charge_len", n, len);
        chk("scan_done_high", scan_done, 1'b1);
        if (last_done >= 0) chk("scan_period", cyc - last_done, DC + len + 1);
        last_done = cyc;
        hit_clear = clr;
        pads = '0;

        old_t = m_touched;
        for (int i = 0; i < N; i++) begin
            bit raw;
            raw = (rise[i] >= THR);
            if (raw == m_touched[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == DS) begin
                    m_touched[i] = raw;
                    m_cnt[i] = 0;
                end
            end
        end
        m_hits = (m_hits & ~clr) | (m_touched & ~old_t);

        tick();
        hit_clear = '0;
        chk("scan_done_low", scan_done, 1'b0);
        chk("touched", touched, m_touched);
        chk("hits", hits, m_hits);
        discharge_check();
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) mode[i] = 0;

        // Reset held 5 cycles with every pad high
        reset = 1'b0;
        pads  = '1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rst_out", sensors_out, 1'b0);
            chk("rst_touched", touched, '0);
            chk("rst_hits", hits, '0);
            chk("rst_scan_done", scan_done, 1'b0);
        end
        reset = 1'b1;
        discharge_check();

        set_all(-2);
        run_scan('0);

        set_all(3);
        run_scan('0);
        run_scan('0);

        // Pad 4 slow for two scans
        kk[4] = 30;
        run_scan('0);
        run_scan('0);
        kk[4] = 3;
        run_scan('0);
        run_scan('0);

        // Pad 0 times out
        kk[0] = -1;
        run_scan('0);
        run_scan('0);
        kk[0] = 3;
        run_scan('0);
        run_scan('0);

        // Clear everything with no new touches
        run_scan('1);

        // Single-scan glitch on pad 4
        kk[4] = 30;
        run_scan('0);
        kk[4] = 3;
        run_scan('0);
        run_scan('0);

        // Clear colliding with a re-rise, then a lone clear
        kk[4] = 30;
        run_scan('0);
        run_scan('0);
        kk[4] = 3;
        run_scan('0);
        run_scan('0);
        kk[4] = 30;
        run_scan('0);
        run_scan(9'h010);
        run_scan(9'h010);

        // Randomised scans
        for (int s = 0; s < 20; s++) begin
            logic [N-1:0] clr;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) mode[i] = 1 - mode[i];
                if (mode[i] == 0)                    kk[i] = $urandom_range(0, 12);
                else if ($urandom_range(0, 5) == 0)  kk[i] = -1;
                else                                 kk[i] = $urandom_range(18, 50);
            end
            clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            run_scan(clr);
        end

        // Build up state, then reset in the middle of a charge phase
        set_all(3);
        kk[2] = 40;
        run_scan('0);
        run_scan('0);
        set_all(-1);
        for (int j = 0; j < 5; j++) tick();
        reset = 1'b0;
        tick();
        chk("midrst_out", sensors_out, 1'b0);
        chk("midrst_touched", touched, '0);
        chk("midrst_hits", hits, '0);
        reset = 1'b1;
        model_reset();
        discharge_check();
        set_all(3);
        run_scan('0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
